// File: rtl/serial_arith_seq_pkg.sv
// Shared definitions for the bit-serial arithmetic sequencer: op codes,
// FSM state encoding and the initial-carry rule.
package serial_arith_seq_pkg;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // INC and SUB both need the +1 injected through the carry of bit 0.
    function automatic logic init_carry(input logic [1:0] op_code);
        return (op_code == OP_INC) || (op_code == OP_SUB);
    endfunction

endpackage

// File: rtl/ctrl_bit_cell.sv
// Controlled full-adder bit cell: {s1,s0} selects the B operand as 0, b, ~b or 1
// before a plain full add with the incoming carry.
module ctrl_bit_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c,
    input  logic s1,
    input  logic s0,
    output logic sum,
    output logic c_next
);

    logic b_eff;

    assign b_eff  = (~s1 & s0 & b_i) | (s1 & ~s0 & ~b_i) | (s1 & s0);
    assign sum    = a_i ^ b_eff ^ c;
    assign c_next = (a_i & b_eff) | (a_i & c) | (b_eff & c);

endmodule

// File: rtl/serial_arith_seq.sv
// Bit-serial INC/ADD/SUB/DEC sequencer: one bit pair per clock, LSB first, through
// a single ctrl_bit_cell. Define OVF_DETECT_EN to register signed overflow on ovf.
module serial_arith_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    import serial_arith_seq_pkg::*;

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [1:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   stage_q, stage_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
`ifdef OVF_DETECT_EN
    logic               ovf_q, ovf_d;
`endif

    logic cell_sum;
    logic cell_c_next;

    ctrl_bit_cell u_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .c      (carry_q),
        .s1     (op_q[1]),
        .s0     (op_q[0]),
        .sum    (cell_sum),
        .c_next (cell_c_next)
    );

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef OVF_DETECT_EN
        ovf_d    = ovf_q;
`endif
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = op;
                    carry_d = init_carry(op);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = cell_c_next;
                stage_d = {cell_sum, stage_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                // The last sum bit bypasses staging so result updates on the same edge.
                if (cnt_q == LAST_BIT) begin
                    result_d = {cell_sum, stage_q[WIDTH-1:1]};
                    cout_d   = cell_c_next;
`ifdef OVF_DETECT_EN
                    ovf_d    = carry_q ^ cell_c_next;
`endif
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            stage_q  <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef OVF_DETECT_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef OVF_DETECT_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
`ifdef OVF_DETECT_EN
    assign ovf    = ovf_q;
`else
    assign ovf    = 1'b0;
`endif

endmodule
